// File: rtl/i2c_txn_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_txn_scheduler
// Shares one byte-level I2C master between the LCD writer and the sensor
// reader. It runs whole multi-byte transactions on the master. Requests are
// arbitrated round-robin. A granted transaction is never preempted.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   lcd_req/addr/len  LCD write transaction request, slave address, byte count
//   lcd_wdata         current LCD write byte; the client advances it on lcd_wnext
//   lcd_wnext         1-cycle pulse: byte taken by the master
//   lcd_done          1-cycle pulse: LCD transaction finished
//   sen_req/addr/len  sensor read transaction request, slave address, byte count
//   sen_rdata/rvalid  received byte and its 1-cycle valid pulse
//   sen_done          1-cycle pulse: sensor transaction finished
//   grant_lcd/sen     high while that client owns the bus
//   err               pulses with *_done when a NACK or timeout aborted the transaction
//   i2c_ena/addr/rw/data_wr  handshake towards the byte-level master
//   i2c_busy/data_rd/ack_error  status from the byte-level master
// All outputs are registered.
// ---------------------------------------------------------------------------
module i2c_txn_scheduler #(
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_req,
    input  logic [6:0]       lcd_addr,
    input  logic [LEN_W-1:0] lcd_len,
    input  logic [7:0]       lcd_wdata,
    output logic             lcd_wnext,
    output logic             lcd_done,
    input  logic             sen_req,
    input  logic [6:0]       sen_addr,
    input  logic [LEN_W-1:0] sen_len,
    output logic [7:0]       sen_rdata,
    output logic             sen_rvalid,
    output logic             sen_done,
    output logic             grant_lcd,
    output logic             grant_sen,
    output logic             err,
    output logic             i2c_ena,
    output logic [6:0]       i2c_addr,
    output logic             i2c_rw,
    output logic [7:0]       i2c_data_wr,
    input  logic             i2c_busy,
    input  logic [7:0]       i2c_data_rd,
    input  logic             i2c_ack_error
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic             busy_q, rise, fall;
    logic             owner_sen, owner_sen_nxt;
    logic             last_sen;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic [LEN_W-1:0] done_cnt, done_cnt_nxt;
    logic             abort, abort_nxt;
    logic [WD_W-1:0]  wd, wd_nxt;
    logic             win_valid, win_sen;
    logic [LEN_W-1:0] win_len;
    logic [6:0]       win_addr;
    logic             active, timeout_hit, nack_fall;

    logic             grant_act_nxt;
    logic             lcd_wnext_nxt, lcd_done_nxt, sen_rvalid_nxt, sen_done_nxt;
    logic             grant_lcd_nxt, grant_sen_nxt, err_nxt, ena_nxt, rw_nxt;
    logic [7:0]       sen_rdata_nxt, data_wr_nxt;
    logic [6:0]       addr_nxt;

    // Busy edges: a rise means the master accepted a byte, a fall means it finished one.
    assign rise = i2c_busy & ~busy_q;
    assign fall = ~i2c_busy & busy_q;

    // Round-robin: a lone requester wins. On a tie, the client served last time loses.
    assign win_valid = lcd_req | sen_req;
    assign win_sen   = sen_req & (~lcd_req | ~last_sen);
    assign win_len   = win_sen ? sen_len : lcd_len;
    assign win_addr  = win_sen ? sen_addr : lcd_addr;

    // The watchdog and NACK handling only matter while bytes can be in flight.
    assign active      = (state == RUN) || (state == DRAIN);
    assign timeout_hit = active && !rise && !fall && (wd == WD_W'(TIMEOUT_CYC - 1));
    assign nack_fall   = active && fall && i2c_ack_error;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. After a NACK the master may still be busy, so DRAIN
    // waits for busy to go low before the transaction is closed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (timeout_hit) begin
                    state_nxt = DONE;
                end else if (nack_fall) begin
                    state_nxt = DRAIN;
                end else if (rise && (rem == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (timeout_hit) begin
                    state_nxt = DONE;
                end else if (abort) begin
                    if (!i2c_busy) begin
                        state_nxt = DONE;
                    end
                end else if (fall) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and datapath next values. Everything is registered in the block
    // below, so each pulse lines up with the state that produces it.
    always_comb begin
        owner_sen_nxt = owner_sen;
        rem_nxt       = rem;
        done_cnt_nxt  = done_cnt;
        abort_nxt     = abort;
        wd_nxt        = (state == IDLE || rise || fall) ? '0 : wd + WD_W'(1);

        if (state == IDLE) begin
            owner_sen_nxt = win_sen;
            rem_nxt       = win_len;
            done_cnt_nxt  = '0;
            abort_nxt     = 1'b0;
        end else begin
            if (state == RUN && rise) begin
                rem_nxt = rem - LEN_W'(1);
            end
            if (fall) begin
                done_cnt_nxt = done_cnt + LEN_W'(1);
            end
            if (timeout_hit || nack_fall) begin
                abort_nxt = 1'b1;
            end
        end

        grant_act_nxt  = (state == IDLE) ? win_valid : (state_nxt != IDLE);
        grant_lcd_nxt  = grant_act_nxt & ~owner_sen_nxt;
        grant_sen_nxt  = grant_act_nxt & owner_sen_nxt;

        lcd_wnext_nxt  = (state == RUN) && rise && !owner_sen;
        sen_rvalid_nxt = (state != IDLE) && fall && owner_sen;
        sen_rdata_nxt  = sen_rvalid_nxt ? i2c_data_rd : sen_rdata;

        lcd_done_nxt   = (state_nxt == DONE) && !owner_sen_nxt;
        sen_done_nxt   = (state_nxt == DONE) && owner_sen_nxt;
        err_nxt        = (state_nxt == DONE) && abort_nxt;

        ena_nxt        = (state_nxt == RUN);
        addr_nxt       = grant_act_nxt ? ((state == IDLE) ? win_addr : i2c_addr) : 7'd0;
        rw_nxt         = grant_act_nxt & owner_sen_nxt;
        data_wr_nxt    = grant_lcd_nxt ? lcd_wdata : 8'd0;
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            owner_sen   <= 1'b0;
            last_sen    <= 1'b0;
            rem         <= '0;
            done_cnt    <= '0;
            abort       <= 1'b0;
            wd          <= '0;
            lcd_wnext   <= 1'b0;
            lcd_done    <= 1'b0;
            sen_rdata   <= 8'd0;
            sen_rvalid  <= 1'b0;
            sen_done    <= 1'b0;
            grant_lcd   <= 1'b0;
            grant_sen   <= 1'b0;
            err         <= 1'b0;
            i2c_ena     <= 1'b0;
            i2c_addr    <= 7'd0;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= 8'd0;
        end else begin
            busy_q      <= i2c_busy;
            owner_sen   <= owner_sen_nxt;
            if (state == DONE) begin
                last_sen <= owner_sen;
            end
            rem         <= rem_nxt;
            done_cnt    <= done_cnt_nxt;
            abort       <= abort_nxt;
            wd          <= wd_nxt;
            lcd_wnext   <= lcd_wnext_nxt;
            lcd_done    <= lcd_done_nxt;
            sen_rdata   <= sen_rdata_nxt;
            sen_rvalid  <= sen_rvalid_nxt;
            sen_done    <= sen_done_nxt;
            grant_lcd   <= grant_lcd_nxt;
            grant_sen   <= grant_sen_nxt;
            err         <= err_nxt;
            i2c_ena     <= ena_nxt;
            i2c_addr    <= addr_nxt;
            i2c_rw      <= rw_nxt;
            i2c_data_wr <= data_wr_nxt;
        end
    end

endmodule
